// File: rtl/bcd_digit_scanner.sv
// Time-multiplexed BCD digit scanner feeding a 7-segment decoder; active-low anode enables.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 always shown).
module bcd_digit_scanner #(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int DIV_W       = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [4*DIGITS-1:0]   digits_in,
  output logic [3:0]            bcd,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_done
);

  localparam int IDX_W = $clog2(DIGITS);

  logic [DIV_W-1:0]           div_cnt;
  logic [IDX_W-1:0]           idx;
  logic                       pend_valid;
  logic [DIGITS-1:0][3:0]     pend_data;
  logic [DIGITS-1:0][3:0]     disp_data;
  logic                       slot;
  logic                       boundary;
  logic                       accept;
  logic [DIGITS-1:0]          blank;

  assign slot     = (div_cnt == DIV_W'(REFRESH_DIV - 1));
  assign boundary = slot && (idx == IDX_W'(DIGITS - 1));

  // Handshake: a word transfers on a rising edge where load_valid & load_ready;
  // the producer holds load_valid/digits_in stable until then. load_ready only
  // reflects the one-deep pending register, so at most one word waits per frame.
  assign load_ready = ~pend_valid;
  assign accept     = load_valid & ~pend_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      idx     <= '0;
    end else if (slot) begin
      div_cnt <= '0;
      idx     <= boundary ? '0 : idx + IDX_W'(1);
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // Display word only changes at the frame boundary so a frame never mixes words.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_valid <= 1'b0;
      pend_data  <= '0;
      disp_data  <= '0;
    end else begin
      if (boundary && pend_valid) begin
        disp_data  <= pend_data;
        pend_valid <= 1'b0;
      end
      if (accept) begin
        pend_data  <= digits_in;
        pend_valid <= 1'b1;
      end
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic zero_run;

  // Digit k blanks when it and every higher nibble are zero; digit 0 never blanks.
  always_comb begin
    zero_run = 1'b1;
    blank    = '0;
    for (int k = DIGITS - 1; k > 0; k--) begin
      zero_run = zero_run & (disp_data[k] == 4'h0);
      blank[k] = zero_run;
    end
  end
`else
  assign blank = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcd        <= 4'h0;
      an         <= '1;
      frame_done <= 1'b0;
    end else begin
      frame_done <= boundary;
      if (blank[idx]) begin
        an  <= '1;
        bcd <= 4'h0;
      end else begin
        an  <= ~(DIGITS'(1) << idx);
        bcd <= disp_data[idx];
      end
    end
  end

endmodule

// File: tb/tb_bcd_digit_scanner.sv
// Self-checking bench for bcd_digit_scanner (DIGITS=4, REFRESH_DIV=4) with a time-based
// reference model; honours LEADING_ZERO_BLANK_EN when the build defines it.
module tb_bcd_digit_scanner;

  localparam int R = 4;
  localparam int D = 4;
  localparam int W = 4 * D;
`ifdef LEADING_ZERO_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic         load_valid;
  logic         load_ready;
  logic [W-1:0] digits_in;
  logic [3:0]   bcd;
  logic [D-1:0] an;
  logic         frame_done;

  bcd_digit_scanner #(.DIGITS(D), .REFRESH_DIV(R), .DIV_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .digits_in  (digits_in),
    .bcd        (bcd),
    .an         (an),
    .frame_done (frame_done)
  );

  // ---------------- reference model ----------------
  // c counts rising edges since reset release; the digit shown after an edge
  // is the one scheduled for the cycle before it.
  int           c;
  logic [W-1:0] m_disp;
  logic [W-1:0] exp_q[$];
  logic [D-1:0] exp_an = '1;
  logic [3:0]   exp_bcd = 4'h0;
  logic         exp_fd = 1'b0;
  int           m_d;
  bit           m_bnd;
  bit           m_take;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c       = 0;
      m_disp  = '0;
      exp_q.delete();
      exp_an  = '1;
      exp_bcd = 4'h0;
      exp_fd  = 1'b0;
    end else begin
      m_d   = (c / R) % D;
      m_bnd = (c % (R * D)) == (R * D - 1);
      if (BLANK && m_d > 0 && (m_disp >> (4 * m_d)) == '0) begin
        exp_an  = '1;
        exp_bcd = 4'h0;
      end else begin
        exp_an  = ~(D'(1) << m_d);
        exp_bcd = 4'((m_disp >> (4 * m_d)) & W'(16'hF));
      end
      exp_fd = m_bnd;
      m_take = load_valid && exp_q.size() == 0;
      if (m_bnd && exp_q.size() != 0) m_disp = exp_q.pop_front();
      if (m_take) exp_q.push_back(digits_in);
      c++;
    end
  end

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  int e       = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, req, e);
    end
  endtask

  task automatic compare_all();
    check("an",         32'(an),         32'(exp_an));
    check("bcd",        32'(bcd),        32'(exp_bcd));
    check("frame_done", 32'(frame_done), 32'(exp_fd));
    check("load_ready", 32'(load_ready), 32'(exp_q.size() == 0));
  endtask

  // ---------------- driver ----------------
  task automatic step(input int k);
    repeat (k) begin
      @(posedge clk);
      e++;
      @(negedge clk);
      compare_all();
    end
  endtask

  task automatic lit(input string name, input logic [D-1:0] an_req, input logic [3:0] bcd_req);
    check({name, ".an"},  32'(an),  32'(an_req));
    check({name, ".bcd"}, 32'(bcd), 32'(bcd_req));
  endtask

  initial begin
    rst_n      = 1'b0;
    load_valid = 1'b0;
    digits_in  = '0;
    step(3);
    lit("reset", 4'b1111, 4'h0);
    check("reset.ready", 32'(load_ready), 32'd1);
    check("reset.fd",    32'(frame_done), 32'd0);
    rst_n = 1'b1;
    e = 0;

    // idle scan
    step(1);
    lit("idle_d0", 4'b1110, 4'h0);
    check("idle.ready", 32'(load_ready), 32'd1);
    check("idle.fd_lo", 32'(frame_done), 32'd0);
    step(15);
    check("idle.fd_hi", 32'(frame_done), 32'd1);
    lit("idle_d3", 4'b0111, 4'h0);

    // load 1234 mid-frame
    load_valid = 1'b1; digits_in = 16'h1234;
    step(1);
    check("l1234.ready_lo", 32'(load_ready), 32'd0);
    load_valid = 1'b0;
    step(15);
    check("l1234.ready_hi", 32'(load_ready), 32'd1);
    check("l1234.fd", 32'(frame_done), 32'd1);
    step(1);  lit("l1234_d0", 4'b1110, 4'h4);
    step(4);  lit("l1234_d1", 4'b1101, 4'h3);
    step(4);  lit("l1234_d2", 4'b1011, 4'h2);
    step(4);  lit("l1234_d3", 4'b0111, 4'h1);

    // back-to-back words 5678 then 9ABC
    load_valid = 1'b1; digits_in = 16'h5678;
    step(1);
    check("b2b.ready_lo", 32'(load_ready), 32'd0);
    digits_in = 16'h9ABC;
    step(2);
    check("b2b.ready_bnd", 32'(load_ready), 32'd1);
    step(1);
    check("b2b.ready_2nd", 32'(load_ready), 32'd0);
    lit("b2b_5678_d0", 4'b1110, 4'h8);
    load_valid = 1'b0;
    step(12); lit("b2b_5678_d3", 4'b0111, 4'h5);
    step(4);  lit("b2b_9abc_d0", 4'b1110, 4'hC);
    step(4);  lit("b2b_9abc_d1", 4'b1101, 4'hB);
    step(4);  lit("b2b_9abc_d2", 4'b1011, 4'hA);
    step(4);  lit("b2b_9abc_d3", 4'b0111, 4'h9);

    // valid raised exactly on the boundary cycle with pending empty
    step(2);
    load_valid = 1'b1; digits_in = 16'h4321;
    step(1);
    check("bnd.fd", 32'(frame_done), 32'd1);
    check("bnd.ready_lo", 32'(load_ready), 32'd0);
    load_valid = 1'b0;
    step(1);  lit("bnd_old_d0", 4'b1110, 4'hC);
    step(15);
    check("bnd.ready_hi", 32'(load_ready), 32'd1);
    step(1);  lit("bnd_new_d0", 4'b1110, 4'h1);

    // reset mid-handshake and mid-digit
    load_valid = 1'b1; digits_in = 16'h8765;
    step(1);
    check("rst.ready_lo", 32'(load_ready), 32'd0);
    digits_in = 16'h1111;
    step(1);
    #2 rst_n = 1'b0;
    #1;
    lit("rst_async", 4'b1111, 4'h0);
    check("rst.ready", 32'(load_ready), 32'd1);
    check("rst.fd",    32'(frame_done), 32'd0);
    load_valid = 1'b0;
    step(2);
    rst_n = 1'b1;
    e = 0;
    step(1);  lit("rst_rel_d0", 4'b1110, 4'h0);
    step(3);  lit("rst_rel_d0_end", 4'b1110, 4'h0);
    step(1);  lit("rst_rel_d1", 4'b1101, 4'h0);

    // leading-zero words 0070 then 0000
    load_valid = 1'b1; digits_in = 16'h0070;
    step(1);
    check("lz.ready_lo", 32'(load_ready), 32'd0);
    load_valid = 1'b0;
    step(11); lit("lz70_d0", 4'b1110, 4'h0);
    step(4);  lit("lz70_d1", 4'b1101, 4'h7);
    load_valid = 1'b1; digits_in = 16'h0000;
    step(1);
    load_valid = 1'b0;
    step(3);  lit("lz70_d2", BLANK ? 4'b1111 : 4'b1011, 4'h0);
    step(4);  lit("lz70_d3", BLANK ? 4'b1111 : 4'b0111, 4'h0);
    step(4);  lit("lz00_d0", 4'b1110, 4'h0);
    step(4);  lit("lz00_d1", BLANK ? 4'b1111 : 4'b1101, 4'h0);
    step(8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at edge %0d", e);
    $fatal(1, "watchdog");
  end

endmodule
